// File: rtl/vending_pkg.sv
// Shared types and constants for the four-drink vending controller.
package vending_pkg;

  localparam int unsigned COIN_W = 32;
  localparam int unsigned ITEM_W = 80;
  localparam int unsigned MENU_W = 240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    EXCH = 2'd2
  } state_t;

  localparam logic [1:0] COND_INFO = 2'b00;
  localparam logic [1:0] COND_OUT  = 2'b01;
  localparam logic [1:0] COND_EXCH = 2'b10;

  localparam logic [3:0] DRINK_NONE   = 4'd0;
  localparam logic [3:0] DRINK_TEA    = 4'd1;
  localparam logic [3:0] DRINK_COKE   = 4'd2;
  localparam logic [3:0] DRINK_COFFEE = 4'd3;
  localparam logic [3:0] DRINK_MILK   = 4'd4;

  localparam logic [COIN_W-1:0] DEF_PRICE_TEA    = 32'd10;
  localparam logic [COIN_W-1:0] DEF_PRICE_COKE   = 32'd15;
  localparam logic [COIN_W-1:0] DEF_PRICE_COFFEE = 32'd20;
  localparam logic [COIN_W-1:0] DEF_PRICE_MILK   = 32'd25;

  // Names are right-justified with zero bytes in the upper positions.
  localparam logic [ITEM_W-1:0] NAME_TEA    = {56'd0, "tea"};
  localparam logic [ITEM_W-1:0] NAME_COKE   = {48'd0, "coke"};
  localparam logic [ITEM_W-1:0] NAME_COFFEE = {32'd0, "coffee"};
  localparam logic [ITEM_W-1:0] NAME_MILK   = {48'd0, "milk"};

  localparam int unsigned LEN_TEA    = 3;
  localparam int unsigned LEN_COKE   = 4;
  localparam int unsigned LEN_COFFEE = 6;
  localparam int unsigned LEN_MILK   = 4;

  localparam logic [23:0] MENU_SEP = " | ";

  localparam logic [COIN_W-1:0] COIN_1  = 32'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 32'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 32'd10;
  localparam logic [COIN_W-1:0] COIN_50 = 32'd50;

  // True only for coin denominations the strict acceptor recognises.
  function automatic logic is_legal_coin(input logic [COIN_W-1:0] c);
    return (c == COIN_1) || (c == COIN_5) || (c == COIN_10) || (c == COIN_50);
  endfunction

  // Maps a drink code to its display name; unknown codes give all zeros.
  function automatic logic [ITEM_W-1:0] drink_name(input logic [3:0] code);
    logic [ITEM_W-1:0] n;
    case (code)
      DRINK_TEA:    n = NAME_TEA;
      DRINK_COKE:   n = NAME_COKE;
      DRINK_COFFEE: n = NAME_COFFEE;
      DRINK_MILK:   n = NAME_MILK;
      default:      n = '0;
    endcase
    return n;
  endfunction

  // Appends a name (and a separator if the string already holds a name)
  // into the low bytes of a right-justified menu string.
  function automatic logic [MENU_W-1:0] menu_append(
    input logic [MENU_W-1:0] s,
    input logic              non_empty,
    input logic [ITEM_W-1:0] name,
    input int unsigned       name_len
  );
    logic [MENU_W-1:0] r;
    r = s;
    if (non_empty) begin
      r = (r << 24) | {{(MENU_W-24){1'b0}}, MENU_SEP};
    end
    r = (r << (name_len * 8)) | {{(MENU_W-ITEM_W){1'b0}}, name};
    return r;
  endfunction

endpackage

// File: rtl/vending_menu_fmt.sv
// Combinational builder of the "affordable drinks" ASCII string.
module vending_menu_fmt
  import vending_pkg::*;
#(
  parameter logic [31:0] PRICE_TEA    = DEF_PRICE_TEA,
  parameter logic [31:0] PRICE_COKE   = DEF_PRICE_COKE,
  parameter logic [31:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
  parameter logic [31:0] PRICE_MILK   = DEF_PRICE_MILK
) (
  input  logic [31:0]       i_total,
  output logic [MENU_W-1:0] o_legal_choice
);

  logic [MENU_W-1:0] w_menu;
  logic              w_any;

  // Walk the drinks in code order, appending each one the balance covers.
  always_comb begin
    w_menu = '0;
    w_any  = 1'b0;
    if (i_total >= PRICE_TEA) begin
      w_menu = menu_append(w_menu, w_any, NAME_TEA, LEN_TEA);
      w_any  = 1'b1;
    end
    if (i_total >= PRICE_COKE) begin
      w_menu = menu_append(w_menu, w_any, NAME_COKE, LEN_COKE);
      w_any  = 1'b1;
    end
    if (i_total >= PRICE_COFFEE) begin
      w_menu = menu_append(w_menu, w_any, NAME_COFFEE, LEN_COFFEE);
      w_any  = 1'b1;
    end
    if (i_total >= PRICE_MILK) begin
      w_menu = menu_append(w_menu, w_any, NAME_MILK, LEN_MILK);
      w_any  = 1'b1;
    end
  end

  assign o_legal_choice = w_menu;

endmodule

// File: rtl/vending_fsm.sv
// Four-drink vending controller: coin accumulation, purchase, change, refund.
// Optional build macro VEND_STRICT_COIN_EN: only 1/5/10/50 coins are accepted.
module vending_fsm
  import vending_pkg::*;
#(
  parameter logic [31:0] PRICE_TEA    = DEF_PRICE_TEA,
  parameter logic [31:0] PRICE_COKE   = DEF_PRICE_COKE,
  parameter logic [31:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
  parameter logic [31:0] PRICE_MILK   = DEF_PRICE_MILK
) (
  input  logic              CLOCK,
  input  logic              CLEAR,
  output logic [31:0]       total_coin,
  output logic [31:0]       exchange_coin,
  output logic [MENU_W-1:0] legal_choice,
  output logic [ITEM_W-1:0] item,
  output logic [1:0]        condition,
  input  logic [31:0]       coin,
  input  logic [3:0]        drink_choose,
  input  logic              cancel
);

  state_t            r_state;
  logic [31:0]       r_total;
  logic [31:0]       r_exch;
  logic [31:0]       r_change;
  logic [ITEM_W-1:0] r_item;
  logic [1:0]        r_cond;

  logic              w_choice_ok;
  logic [31:0]       w_price;
  logic [ITEM_W-1:0] w_name;
  logic [32:0]       w_sum;
  logic [31:0]       w_coin_total;
  logic              w_coin_ok;

  // Decode the keypad code into a price and a name; codes outside 1..4 are not selections.
  always_comb begin
    w_choice_ok = 1'b1;
    w_price     = '0;
    case (drink_choose)
      DRINK_TEA:    w_price = PRICE_TEA;
      DRINK_COKE:   w_price = PRICE_COKE;
      DRINK_COFFEE: w_price = PRICE_COFFEE;
      DRINK_MILK:   w_price = PRICE_MILK;
      default:      w_choice_ok = 1'b0;
    endcase
  end

  assign w_name       = drink_name(drink_choose);
  assign w_sum        = {1'b0, r_total} + {1'b0, coin};
  assign w_coin_total = w_sum[32] ? '1 : w_sum[31:0];

`ifdef VEND_STRICT_COIN_EN
  assign w_coin_ok = is_legal_coin(coin);
`else
  assign w_coin_ok = (coin != '0);
`endif

  // Controller state and all registered outputs advance together on the clock edge.
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      r_state  <= IDLE;
      r_total  <= '0;
      r_exch   <= '0;
      r_change <= '0;
      r_item   <= '0;
      r_cond   <= COND_INFO;
    end else begin
      case (r_state)
        IDLE: begin
          r_exch <= '0;
          r_item <= '0;
          r_cond <= COND_INFO;
          if (cancel) begin
            r_exch  <= r_total;
            r_total <= '0;
            r_cond  <= COND_EXCH;
            r_state <= EXCH;
          end else if (w_choice_ok) begin
            if (r_total >= w_price) begin
              r_change <= r_total - w_price;
              r_item   <= w_name;
              r_cond   <= COND_OUT;
              r_state  <= OUT;
            end
          end else if (w_coin_ok) begin
            r_total <= w_coin_total;
          end
        end
        OUT: begin
          r_exch  <= r_change;
          r_total <= '0;
          r_item  <= '0;
          r_cond  <= COND_EXCH;
          r_state <= EXCH;
        end
        EXCH: begin
          r_exch  <= '0;
          r_item  <= '0;
          r_cond  <= COND_INFO;
          r_state <= IDLE;
        end
        default: begin
          r_exch  <= '0;
          r_item  <= '0;
          r_cond  <= COND_INFO;
          r_state <= IDLE;
        end
      endcase
    end
  end

  vending_menu_fmt #(
    .PRICE_TEA    (PRICE_TEA),
    .PRICE_COKE   (PRICE_COKE),
    .PRICE_COFFEE (PRICE_COFFEE),
    .PRICE_MILK   (PRICE_MILK)
  ) u_menu (
    .i_total        (r_total),
    .o_legal_choice (legal_choice)
  );

  assign total_coin    = r_total;
  assign exchange_coin = r_exch;
  assign item          = r_item;
  assign condition     = r_cond;

endmodule

// File: tb/tb_vending_fsm.sv
// Scoreboard bench for vending_fsm: a behavioural model queues the expected
// outputs for each driven cycle and every test task checks them after the edge.
module tb_vending_fsm;

  logic         CLOCK = 1'b0;
  logic         CLEAR = 1'b1;
  logic [31:0]  coin = '0;
  logic [3:0]   drink_choose = '0;
  logic         cancel = 1'b0;
  logic [31:0]  total_coin;
  logic [31:0]  exchange_coin;
  logic [239:0] legal_choice;
  logic [79:0]  item;
  logic [1:0]   condition;

  vending_fsm dut (
    .CLOCK         (CLOCK),
    .CLEAR         (CLEAR),
    .total_coin    (total_coin),
    .exchange_coin (exchange_coin),
    .legal_choice  (legal_choice),
    .item          (item),
    .condition     (condition),
    .coin          (coin),
    .drink_choose  (drink_choose),
    .cancel        (cancel)
  );

  // Free-running clock, 10 time units per period.
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [31:0] coin;
    logic [3:0]  choose;
    logic        cancel;
    logic        clr;
  } stim_t;

  typedef struct {
    logic [1:0]  cond;
    logic [31:0] total;
    logic [31:0] exch;
    logic [79:0] item;
  } exp_t;

  exp_t        sbQ[$];
  stim_t       stimQ[$];
  logic [31:0] exchSeen[$];
  logic [79:0] itemSeen[$];
  int          nCompared = 0;
  int          nMismatched = 0;

  int          mState = 0;
  logic [31:0] mTotal = '0;
  logic [31:0] mChange = '0;

  function automatic logic [31:0] priceOf(input int c);
    case (c)
      1: return 32'd10;
      2: return 32'd15;
      3: return 32'd20;
      default: return 32'd25;
    endcase
  endfunction

  function automatic string nameOf(input int c);
    case (c)
      1: return "tea";
      2: return "coke";
      3: return "coffee";
      default: return "milk";
    endcase
  endfunction

  function automatic logic [239:0] packStr(input string s);
    logic [239:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v = (v << 8) | {232'd0, s[i]};
    return v;
  endfunction

  function automatic logic [79:0] packItem(input string s);
    logic [239:0] v;
    v = packStr(s);
    return v[79:0];
  endfunction

  function automatic logic [239:0] expMenu(input logic [31:0] t);
    string s;
    s = "";
    if (t >= 32'd10) s = "tea";
    if (t >= 32'd15) s = {s, " | coke"};
    if (t >= 32'd20) s = {s, " | coffee"};
    if (t >= 32'd25) s = {s, " | milk"};
    return packStr(s);
  endfunction

  task automatic addStim(input logic [31:0] c, input logic [3:0] ch, input logic ca, input logic cl);
    stim_t s;
    s.coin = c; s.choose = ch; s.cancel = ca; s.clr = cl;
    stimQ.push_back(s);
  endtask

  // Drive one cycle, predict the post-edge outputs and queue them.
  task automatic drive(input stim_t s);
    exp_t        e;
    logic [32:0] sum;
    logic        ok;
    @(negedge CLOCK);
    coin = s.coin; drink_choose = s.choose; cancel = s.cancel; CLEAR = s.clr;
    e.cond = 2'b00; e.exch = '0; e.item = '0;
    if (s.clr) begin
      mState = 0; mTotal = '0; mChange = '0;
    end else begin
      case (mState)
        0: begin
          if (s.cancel) begin
            e.cond = 2'b10; e.exch = mTotal; mTotal = '0; mState = 2;
          end else if (s.choose >= 4'd1 && s.choose <= 4'd4) begin
            if (mTotal >= priceOf(int'(s.choose))) begin
              e.cond = 2'b01;
              e.item = packItem(nameOf(int'(s.choose)));
              mChange = mTotal - priceOf(int'(s.choose));
              mState = 1;
            end
          end else begin
            ok = (s.coin != 32'd0);
`ifdef VEND_STRICT_COIN_EN
            ok = s.coin inside {32'd1, 32'd5, 32'd10, 32'd50};
`endif
            if (ok) begin
              sum = {1'b0, mTotal} + {1'b0, s.coin};
              mTotal = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            end
          end
        end
        1: begin
          e.cond = 2'b10; e.exch = mChange; mTotal = '0; mState = 2;
        end
        default: mState = 0;
      endcase
    end
    e.total = mTotal;
    sbQ.push_back(e);
    @(posedge CLOCK);
    #1;
    coin = '0; drink_choose = '0; cancel = 1'b0; CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   k;
    $display("[TB] test_reset");
    stimQ.delete();
    addStim(32'd0, 4'd0, 1'b0, 1'b1);
    addStim(32'd0, 4'd0, 1'b0, 1'b1);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL reset.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL reset.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL reset.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL reset.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== 240'd0) begin nMismatched++; $display("[TB] FAIL reset.legal step %0d got %h want 0", k, legal_choice); end
      k++;
    end
  endtask

  task automatic test_purchase();
    exp_t e;
    int   k;
    $display("[TB] test_purchase");
    stimQ.delete(); exchSeen.delete(); itemSeen.delete();
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd5, 4'd0, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd3, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd5, 4'd0, 1'b0, 1'b0);
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd1, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd50, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd5, 4'd0, 1'b0, 1'b0);  addStim(32'd1, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd2, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd50, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd4, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      if (condition == 2'b10) exchSeen.push_back(exchange_coin);
      if (condition == 2'b01) itemSeen.push_back(item);
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL purchase.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL purchase.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL purchase.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL purchase.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== expMenu(e.total)) begin nMismatched++; $display("[TB] FAIL purchase.legal step %0d got %h want %h", k, legal_choice, expMenu(e.total)); end
      k++;
    end
    nCompared++;
    if (exchSeen.size() != 4 || exchSeen[0] !== 32'd6 || exchSeen[1] !== 32'd16 || exchSeen[2] !== 32'd51 || exchSeen[3] !== 32'd46) begin
      nMismatched++; $display("[TB] FAIL purchase.changeList got %0d entries, want 6,16,51,46", exchSeen.size());
    end
    nCompared++;
    if (itemSeen.size() != 4 || itemSeen[0] !== packItem("coffee") || itemSeen[1] !== packItem("tea") || itemSeen[2] !== packItem("coke") || itemSeen[3] !== packItem("milk")) begin
      nMismatched++; $display("[TB] FAIL purchase.itemList got %0d entries, want coffee,tea,coke,milk", itemSeen.size());
    end
  endtask

  task automatic test_insufficient_cancel();
    exp_t e;
    int   k;
    $display("[TB] test_insufficient_cancel");
    stimQ.delete(); exchSeen.delete();
    addStim(32'd5, 4'd0, 1'b0, 1'b0);  addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd4, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd5, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd0, 1'b1, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd0, 1'b1, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd0, 1'b1, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      if (condition == 2'b10) exchSeen.push_back(exchange_coin);
      if (k == 2) begin
        nCompared++; if (total_coin !== 32'd15 || condition !== 2'b00) begin nMismatched++; $display("[TB] FAIL insufficient.hold got total %0d cond %b want 15 00", total_coin, condition); end
        nCompared++; if (legal_choice !== packStr("tea | coke")) begin nMismatched++; $display("[TB] FAIL insufficient.menu got %h want tea | coke", legal_choice); end
      end
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL cancel.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL cancel.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL cancel.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL cancel.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== expMenu(e.total)) begin nMismatched++; $display("[TB] FAIL cancel.legal step %0d got %h want %h", k, legal_choice, expMenu(e.total)); end
      k++;
    end
    nCompared++;
    if (exchSeen.size() != 3 || exchSeen[0] !== 32'd21 || exchSeen[1] !== 32'd10 || exchSeen[2] !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL cancel.refundList got %0d entries, want 21,10,0", exchSeen.size());
    end
  endtask

  task automatic test_priority_clear();
    exp_t e;
    int   k;
    $display("[TB] test_priority_clear");
    stimQ.delete();
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd5, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd1, 1'b1, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd3, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b1); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd0, 4'd1, 1'b0, 1'b0);
    addStim(32'd0, 4'd0, 1'b0, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b1); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      if (k == 4) begin
        nCompared++; if (condition !== 2'b10 || exchange_coin !== 32'd26 || item !== 80'd0) begin nMismatched++; $display("[TB] FAIL priority.refund got cond %b exch %0d item %h want 10 26 0", condition, exchange_coin, item); end
      end
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL clear.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL clear.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL clear.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL clear.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== expMenu(e.total)) begin nMismatched++; $display("[TB] FAIL clear.legal step %0d got %h want %h", k, legal_choice, expMenu(e.total)); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   k;
    $display("[TB] test_back_to_back");
    stimQ.delete();
    addStim(32'd10, 4'd0, 1'b0, 1'b0); addStim(32'd10, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd1, 1'b0, 1'b0);
    addStim(32'd50, 4'd2, 1'b1, 1'b0); addStim(32'd5, 4'd3, 1'b0, 1'b0);
    addStim(32'd1, 4'd0, 1'b0, 1'b0);  addStim(32'd10, 4'd7, 1'b0, 1'b0);
    addStim(32'd0, 4'd15, 1'b0, 1'b0);
    addStim(32'hFFFF_FFF0, 4'd0, 1'b0, 1'b0); addStim(32'h20, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd0, 1'b1, 1'b0);  addStim(32'd0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL b2b.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL b2b.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL b2b.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL b2b.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== expMenu(e.total)) begin nMismatched++; $display("[TB] FAIL b2b.legal step %0d got %h want %h", k, legal_choice, expMenu(e.total)); end
      k++;
    end
  endtask

  task automatic test_coin_filter();
    exp_t        e;
    int          k;
    logic [31:0] want7;
    $display("[TB] test_coin_filter");
`ifdef VEND_STRICT_COIN_EN
    want7 = 32'd0;
`else
    want7 = 32'd7;
`endif
    stimQ.delete();
    addStim(32'd7, 4'd0, 1'b0, 1'b0); addStim(32'd3, 4'd0, 1'b0, 1'b0);
    addStim(32'd0, 4'd0, 1'b1, 1'b0); addStim(32'd0, 4'd0, 1'b0, 1'b0);
    k = 0;
    while (stimQ.size() > 0) begin
      drive(stimQ.pop_front());
      e = sbQ.pop_front();
      if (k == 0) begin
        nCompared++; if (total_coin !== want7) begin nMismatched++; $display("[TB] FAIL filter.coin7 got %0d want %0d", total_coin, want7); end
      end
      nCompared++; if (condition !== e.cond) begin nMismatched++; $display("[TB] FAIL filter.cond step %0d got %b want %b", k, condition, e.cond); end
      nCompared++; if (total_coin !== e.total) begin nMismatched++; $display("[TB] FAIL filter.total step %0d got %0d want %0d", k, total_coin, e.total); end
      nCompared++; if (exchange_coin !== e.exch) begin nMismatched++; $display("[TB] FAIL filter.exch step %0d got %0d want %0d", k, exchange_coin, e.exch); end
      nCompared++; if (item !== e.item) begin nMismatched++; $display("[TB] FAIL filter.item step %0d got %h want %h", k, item, e.item); end
      nCompared++; if (legal_choice !== expMenu(e.total)) begin nMismatched++; $display("[TB] FAIL filter.legal step %0d got %h want %h", k, legal_choice, expMenu(e.total)); end
      k++;
    end
  endtask

  // Guard against a stalled simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t, want summary before 200000", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    test_reset();
    test_purchase();
    test_insufficient_cancel();
    test_priority_clear();
    test_back_to_back();
    test_coin_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
